alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage_if.sv | 33 +++
 rtl/alu_exec_stage.sv | 138 +++++++++++++
 tb/tb_alu_exec_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage_if
// Description : Handshake and data bundle for the Y86-64 execute stage.
//               master = upstream/downstream environment, slave = the stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_exec_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic        cc_en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc_out;

    modport master (
        output in_valid, icode, ifun, valA, valB, valC, cc_en, out_ready,
        input  in_ready, out_valid, valE, cnd, cc_out
    );

    modport slave (
        input  in_valid, icode, ifun, valA, valB, valC, cc_en, out_ready,
        output in_ready, out_valid, valE, cnd, cc_out
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_stage
// Description : Single-cycle Y86-64 execute stage with a one-entry output
//               register, valid/ready handshake and condition-code register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_stage #(
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  wire logic        clk,
    input  wire logic        rst,
    alu_exec_stage_if.slave  bus
);

    localparam logic [3:0] c_icode_cmov  = 4'h2;
    localparam logic [3:0] c_icode_irmov = 4'h3;
    localparam logic [3:0] c_icode_rmmov = 4'h4;
    localparam logic [3:0] c_icode_mrmov = 4'h5;
    localparam logic [3:0] c_icode_opq   = 4'h6;
    localparam logic [3:0] c_icode_jxx   = 4'h7;
    localparam logic [3:0] c_icode_call  = 4'h8;
    localparam logic [3:0] c_icode_ret   = 4'h9;
    localparam logic [3:0] c_icode_push  = 4'hA;
    localparam logic [3:0] c_icode_pop   = 4'hB;
    localparam logic [63:0] c_word_bytes = 64'd8;

    logic        r_out_valid;
    logic [63:0] r_val_e;
    logic        r_cnd;
    logic [2:0]  r_cc;          // {ZF, SF, OF}

    logic        w_in_ready;
    logic        w_take;
    logic        w_cond;
    logic [63:0] w_val_e;
    logic        w_cnd;
    logic        w_new_of;
    logic        w_cc_upd;
    logic [2:0]  w_cc_next;

    // The output slot is free when empty or being drained this cycle.
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_take     = bus.in_valid && w_in_ready;

    // Branch/move condition evaluated against the CC value before this edge.
    always_comb begin
        w_cond = 1'b0;
        case (bus.ifun)
            4'h0: w_cond = 1'b1;
            4'h1: w_cond = (r_cc[1] ^ r_cc[0]) | r_cc[2];
            4'h2: w_cond = r_cc[1] ^ r_cc[0];
            4'h3: w_cond = r_cc[2];
            4'h4: w_cond = !r_cc[2];
            4'h5: w_cond = !(r_cc[1] ^ r_cc[0]);
            4'h6: w_cond = !(r_cc[1] ^ r_cc[0]) && !r_cc[2];
            default: w_cond = 1'b0;
        endcase
    end

    // Execute datapath: result, condition and candidate CC update per icode.
    always_comb begin
        w_val_e  = '0;
        w_cnd    = 1'b0;
        w_new_of = 1'b0;
        w_cc_upd = 1'b0;
        case (bus.icode)
            c_icode_cmov: begin
                w_val_e = bus.valA;
                w_cnd   = w_cond;
            end
            c_icode_irmov: w_val_e = bus.valC;
            c_icode_rmmov,
            c_icode_mrmov: w_val_e = bus.valB + bus.valC;
            c_icode_opq: begin
                case (bus.ifun)
                    4'h0: begin
                        w_val_e  = bus.valB + bus.valA;
                        w_new_of = (bus.valA[63] == bus.valB[63]) &&
                                   (w_val_e[63] != bus.valB[63]);
                        w_cc_upd = bus.cc_en;
                    end
                    4'h1: begin
                        w_val_e  = bus.valB - bus.valA;
                        w_new_of = (bus.valA[63] != bus.valB[63]) &&
                                   (w_val_e[63] != bus.valB[63]);
                        w_cc_upd = bus.cc_en;
                    end
                    4'h2: begin
                        w_val_e  = bus.valB & bus.valA;
                        w_cc_upd = bus.cc_en;
                    end
                    4'h3: begin
                        w_val_e  = bus.valB ^ bus.valA;
                        w_cc_upd = bus.cc_en;
                    end
                    default: w_val_e = '0;
                endcase
            end
            c_icode_jxx: w_cnd = w_cond;
            c_icode_call,
            c_icode_push: w_val_e = bus.valB - c_word_bytes;
            c_icode_ret,
            c_icode_pop:  w_val_e = bus.valB + c_word_bytes;
            default: w_val_e = '0;
        endcase
        w_cc_next = {(w_val_e == 64'd0), w_val_e[63], w_new_of};
    end

    // Output register and CC register; reset discards any held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_val_e     <= '0;
            r_cnd       <= 1'b0;
            r_cc        <= CC_RESET;
        end else begin
            if (w_take) begin
                r_out_valid <= 1'b1;
                r_val_e     <= w_val_e;
                r_cnd       <= w_cnd;
                if (w_cc_upd) begin
                    r_cc <= w_cc_next;
                end
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.valE      = r_val_e;
    assign bus.cnd       = r_cnd;
    assign bus.cc_out    = r_cc;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_stage
// Description : Directed-vector bench for alu_exec_stage. The driver pushes
//               the hand-computed response on each accepted instruction; a
//               monitor pops and compares whenever a result is consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_stage;

    typedef struct {
        logic [63:0] e;
        logic        c;
        logic [2:0]  cc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    alu_exec_stage_if bus();

    alu_exec_stage #(.CC_RESET(3'b100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present an instruction and wait (bounded) for it to be accepted.
    task automatic send(input string name, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic en, input logic [63:0] e, input logic cd,
                        input logic [2:0] cc);
        logic rdy;
        exp_t x;
        bus.in_valid = 1'b1;
        bus.icode = ic; bus.ifun = fn;
        bus.valA = a; bus.valB = b; bus.valC = c; bus.cc_en = en;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                x.e = e; x.c = cd; x.cc = cc; x.name = name;
                sb.push_back(x);
                return;
            end
        end
        chk({name, "_accept_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every result consumed by downstream is checked against the queue.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", bus.valE, 64'hDEAD);
                end else begin
                    x = sb.pop_front();
                    chk({x.name, "_valE"}, bus.valE, x.e);
                    chk({x.name, "_cnd"}, {63'd0, bus.cnd}, {63'd0, x.c});
                    chk({x.name, "_cc"}, {61'd0, bus.cc_out}, {61'd0, x.cc});
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        bus.in_valid = 1'b0; bus.icode = '0; bus.ifun = '0;
        bus.valA = '0; bus.valB = '0; bus.valC = '0; bus.cc_en = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state.
        #12;
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_cc", {61'd0, bus.cc_out}, 64'h4);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // SUB equal then dependent jE; ADD overflow; XOR without CC enable.
        send("sub_eq",  4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1, 64'd0, 1'b0, 3'b100);
        send("je",      4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b100);
        send("add_ovf", 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1,
             64'h8000_0000_0000_0000, 1'b0, 3'b011);
        send("xor_nocc", 4'h6, 4'h3, 64'hFF, 64'hFF, 64'd0, 1'b0, 64'd0, 1'b0, 3'b011);
        send("jle",     4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b011);
        send("jge",     4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b011);
        send("jl",      4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b011);
        send("cmovg",   4'h2, 4'h6, 64'hABCD, 64'd1, 64'd2, 1'b0, 64'hABCD, 1'b1, 3'b011);
        send("pushq",   4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1, 64'hF8, 1'b0, 3'b011);
        send("popq",    4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 1'b1, 64'h108, 1'b0, 3'b011);
        send("irmovq",  4'h3, 4'h0, 64'd7, 64'd9, 64'h1234, 1'b0, 64'h1234, 1'b0, 3'b011);
        send("rmmovq",  4'h4, 4'h0, 64'd0, 64'h10, 64'h20, 1'b0, 64'h30, 1'b0, 3'b011);
        send("mrmovq",  4'h5, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 64'd1, 1'b0, 3'b011);
        send("call",    4'h8, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0, 64'hF8, 1'b0, 3'b011);
        send("ret",     4'h9, 4'h0, 64'd0, 64'h100, 64'd0, 1'b0, 64'h108, 1'b0, 3'b011);
        send("and",     4'h6, 4'h2, 64'hF0, 64'h3C, 64'd0, 1'b1, 64'h30, 1'b0, 3'b000);
        send("op_bad",  4'h6, 4'h4, 64'd1, 64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 3'b000);
        send("halt",    4'h0, 4'h0, 64'd3, 64'd3, 64'd3, 1'b1, 64'd0, 1'b0, 3'b000);
        send("jmp",     4'h7, 4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b000);
        send("jbad",    4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b000);
        send("sub_ovf", 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001);
        send("jl_ovf",  4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b001);
        send("jne",     4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b001);
        idle(3);

        // Backpressure: hold 0x10 for three cycles with a pending instruction.
        bus.out_ready = 1'b0;
        send("bp_first", 4'h3, 4'h0, 64'd0, 64'd0, 64'h10, 1'b0, 64'h10, 1'b0, 3'b001);
        bus.icode = 4'h3; bus.valC = 64'h20; bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
            chk("bp_hold_valE", bus.valE, 64'h10);
            chk("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        begin
            exp_t x;
            x.e = 64'h20; x.c = 1'b0; x.cc = 3'b001; x.name = "bp_second";
            sb.push_back(x);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_reload_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_reload_valE", bus.valE, 64'h20);
        idle(3);

        // Asynchronous reset while a result is held.
        bus.out_ready = 1'b0;
        send("rst_held", 4'h3, 4'h0, 64'd0, 64'd0, 64'h55, 1'b0, 64'h55, 1'b0, 3'b001);
        bus.in_valid = 1'b0;
        #2;
        chk("pre_rst_valE", bus.valE, 64'h55);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("async_rst_valE", bus.valE, 64'd0);
        chk("async_rst_cnd", {63'd0, bus.cnd}, 64'd0);
        chk("async_rst_cc", {61'd0, bus.cc_out}, 64'h4);
        sb.delete();
        @(negedge clk);
        chk("rst_in_ready2", {63'd0, bus.in_ready}, 64'd1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send("post_rst_add", 4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 1'b1, 64'd5, 1'b0, 3'b000);
        idle(2);

        for (int t = 0; t < 100 && sb.size() != 0; t++) @(posedge clk);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
